// File: rtl/rf_bypass_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_bypass_pipe_pkg : default geometry shared by the register file datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
package rf_bypass_pipe_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_SEL_W    = 3;
  localparam int DEF_NUM_REGS = 8;

endpackage : rf_bypass_pipe_pkg
`default_nettype wire

// File: rtl/rf_bypass_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_bypass_sel : per-port youngest-value selector (write, stage, array)
// Revision: 1.0
// ---------------------------------------------------------------------------
module rf_bypass_sel
  import rf_bypass_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit ZERO_REG = 1'b0,
  parameter bit WB_STAGE = 1'b0
) (
  input  logic [SEL_W-1:0]  regsel,
  input  logic              wr_acc,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stage_valid,
  input  logic [SEL_W-1:0]  stage_sel,
  input  logic [DATA_W-1:0] stage_data,
  input  logic [DATA_W-1:0] array_word,
  output logic [DATA_W-1:0] rdata
);

  logic in_range;
  logic is_zero;

  assign in_range = 32'(regsel) < NUM_REGS;
  assign is_zero  = ZERO_REG && (regsel == '0);

  always_comb begin
    rdata = array_word;
    if (!in_range || is_zero) begin
      rdata = '0;
    end else if (wr_acc && (wr_sel == regsel)) begin
      rdata = wr_data;
    end else if (WB_STAGE && stage_valid && (stage_sel == regsel)) begin
      rdata = stage_data;
    end
  end

endmodule : rf_bypass_sel
`default_nettype wire

// File: rtl/rf_bypass_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_bypass_pipe : 2R/1W register file with full bypass and optional WB stage
// Revision: 1.0
// ---------------------------------------------------------------------------
module rf_bypass_pipe
  import rf_bypass_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = DEF_SEL_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit WB_STAGE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  read1regsel,
  input  logic [SEL_W-1:0]  read2regsel,
  input  logic [SEL_W-1:0]  writeregsel,
  input  logic [DATA_W-1:0] writedata,
  input  logic              write,
  output logic [DATA_W-1:0] read1data,
  output logic [DATA_W-1:0] read2data,
  output logic              err
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              wr_acc;
  logic              stage_valid;
  logic [SEL_W-1:0]  stage_sel;
  logic [DATA_W-1:0] stage_data;
  logic              commit_en;
  logic [SEL_W-1:0]  commit_sel;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] port1_data;
  logic [DATA_W-1:0] port2_data;

  assign wr_acc = write && (32'(writeregsel) < NUM_REGS)
                  && !(ZERO_REG && (writeregsel == '0));

  generate
    if (WB_STAGE) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage_valid <= 1'b0;
          stage_sel   <= '0;
          stage_data  <= '0;
        end else begin
          stage_valid <= wr_acc;
          stage_sel   <= writeregsel;
          stage_data  <= writedata;
        end
      end
      assign commit_en   = stage_valid;
      assign commit_sel  = stage_sel;
      assign commit_data = stage_data;
    end else begin : g_direct
      assign stage_valid = 1'b0;
      assign stage_sel   = '0;
      assign stage_data  = '0;
      assign commit_en   = wr_acc;
      assign commit_sel  = writeregsel;
      assign commit_data = writedata;
    end
  endgenerate

  // commit_sel is always in range: only accepted writes ever reach it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit_en) begin
      mem[commit_sel] <= commit_data;
    end
  end

  rf_bypass_sel #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG), .WB_STAGE(WB_STAGE)
  ) u_sel1 (
    .regsel(read1regsel), .wr_acc(wr_acc), .wr_sel(writeregsel),
    .wr_data(writedata), .stage_valid(stage_valid), .stage_sel(stage_sel),
    .stage_data(stage_data), .array_word(mem[read1regsel]), .rdata(port1_data)
  );

  rf_bypass_sel #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG), .WB_STAGE(WB_STAGE)
  ) u_sel2 (
    .regsel(read2regsel), .wr_acc(wr_acc), .wr_sel(writeregsel),
    .wr_data(writedata), .stage_valid(stage_valid), .stage_sel(stage_sel),
    .stage_data(stage_data), .array_word(mem[read2regsel]), .rdata(port2_data)
  );

  // reset forces quiet outputs even while bypass inputs are live
  assign read1data = rst ? port1_data : '0;
  assign read2data = rst ? port2_data : '0;
  assign err = rst & ((write & (32'(writeregsel) >= NUM_REGS))
                      | (32'(read1regsel) >= NUM_REGS)
                      | (32'(read2regsel) >= NUM_REGS));

endmodule : rf_bypass_pipe
`default_nettype wire

// File: tb/tb_rf_bypass_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rf_bypass_pipe : scoreboard bench over four register file configurations
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rf_bypass_pipe;

  // 0: WB_STAGE=0  1: WB_STAGE=1  2: WB_STAGE=1,ZERO_REG=1  3: WB_STAGE=1,NUM_REGS=6
  localparam int N_DUT = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  s1 [N_DUT];
  logic [2:0]  s2 [N_DUT];
  logic [2:0]  ws [N_DUT];
  logic [15:0] wd [N_DUT];
  logic        wr [N_DUT];
  logic [15:0] d1 [N_DUT];
  logic [15:0] d2 [N_DUT];
  logic        er [N_DUT];

  typedef struct {
    int          id;
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ee;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rf_bypass_pipe #(.WB_STAGE(1'b0)) u0 (
    .clk(clk), .rst(rst), .read1regsel(s1[0]), .read2regsel(s2[0]),
    .writeregsel(ws[0]), .writedata(wd[0]), .write(wr[0]),
    .read1data(d1[0]), .read2data(d2[0]), .err(er[0]));

  rf_bypass_pipe #(.WB_STAGE(1'b1)) u1 (
    .clk(clk), .rst(rst), .read1regsel(s1[1]), .read2regsel(s2[1]),
    .writeregsel(ws[1]), .writedata(wd[1]), .write(wr[1]),
    .read1data(d1[1]), .read2data(d2[1]), .err(er[1]));

  rf_bypass_pipe #(.WB_STAGE(1'b1), .ZERO_REG(1'b1)) u2 (
    .clk(clk), .rst(rst), .read1regsel(s1[2]), .read2regsel(s2[2]),
    .writeregsel(ws[2]), .writedata(wd[2]), .write(wr[2]),
    .read1data(d1[2]), .read2data(d2[2]), .err(er[2]));

  rf_bypass_pipe #(.WB_STAGE(1'b1), .NUM_REGS(6)) u3 (
    .clk(clk), .rst(rst), .read1regsel(s1[3]), .read2regsel(s2[3]),
    .writeregsel(ws[3]), .writedata(wd[3]), .write(wr[3]),
    .read1data(d1[3]), .read2data(d2[3]), .err(er[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every queued expectation is
  // checked at the falling edge of the cycle it was issued in.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_cmp++;
      if (d1[x.id] !== x.e1 || d2[x.id] !== x.e2 || er[x.id] !== x.ee) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got rd1=%h rd2=%h err=%b, want rd1=%h rd2=%h err=%b",
                 x.name, x.id, d1[x.id], d2[x.id], er[x.id], x.e1, x.e2, x.ee);
      end
    end
  end

  task automatic clear_writes();
    for (int i = 0; i < N_DUT; i++) wr[i] = 1'b0;
  endtask

  task automatic step(input int id, input string name,
                      input logic w, input logic [2:0] wsel, input logic [15:0] wdat,
                      input logic [2:0] r1, input logic [2:0] r2,
                      input logic [15:0] e1, input logic [15:0] e2, input logic ee);
    exp_t x;
    @(posedge clk);
    #1;
    clear_writes();
    wr[id] = w;
    ws[id] = wsel;
    wd[id] = wdat;
    s1[id] = r1;
    s2[id] = r2;
    x.id = id; x.name = name; x.e1 = e1; x.e2 = e2; x.ee = ee;
    q.push_back(x);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    clear_writes();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      s1[i] = '0; s2[i] = '0; ws[i] = '0; wd[i] = '0; wr[i] = 1'b0;
    end

    // Outputs held quiet during reset despite live write/out-of-range inputs
    step(3, "in_reset_err_masked", 1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd6, 16'h0, 16'h0, 1'b0);
    step(0, "in_reset_no_bypass",  1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 16'h0, 16'h0, 1'b0);
    release_reset();

    for (int r = 0; r < 8; r++) begin
      step(0, "reset_read_ws0", 1'b0, 3'd0, 16'h0, 3'(r), 3'(7 - r), 16'h0, 16'h0, 1'b0);
      step(1, "reset_read_ws1", 1'b0, 3'd0, 16'h0, 3'(r), 3'(7 - r), 16'h0, 16'h0, 1'b0);
    end
    for (int r = 0; r < 6; r++)
      step(3, "reset_read_n6", 1'b0, 3'd0, 16'h0, 3'(r), 3'(5 - r), 16'h0, 16'h0, 1'b0);

    // Direct write: same-cycle bypass, then array
    step(0, "ws0_bypass", 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd4, 16'hBEEF, 16'h0000, 1'b0);
    step(0, "ws0_array",  1'b0, 3'd3, 16'h0000, 3'd3, 3'd4, 16'hBEEF, 16'h0000, 1'b0);

    // Staged write: bypass, overwrite over stage, stage, array
    step(1, "ws1_bypass_first", 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234, 1'b0);
    step(1, "ws1_new_over_stg", 1'b1, 3'd5, 16'h5678, 3'd5, 3'd5, 16'h5678, 16'h5678, 1'b0);
    step(1, "ws1_from_stage",   1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 16'h5678, 16'h0000, 1'b0);
    step(1, "ws1_from_array",   1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'h5678, 16'h5678, 1'b0);

    // Both ports on r2 while r2 is written and also staged
    step(1, "r2_stage_fill",  1'b1, 3'd2, 16'h0F0F, 3'd2, 3'd2, 16'h0F0F, 16'h0F0F, 1'b0);
    step(1, "r2_write_wins",  1'b1, 3'd2, 16'h00FF, 3'd2, 3'd2, 16'h00FF, 16'h00FF, 1'b0);
    step(1, "r2_stage_read",  1'b0, 3'd2, 16'h0000, 3'd2, 3'd2, 16'h00FF, 16'h00FF, 1'b0);
    step(1, "r2_array_read",  1'b0, 3'd2, 16'h0000, 3'd2, 3'd2, 16'h00FF, 16'h00FF, 1'b0);

    // Zero register ignores writes, other registers unaffected
    step(2, "zr_write_r0",   1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0);
    step(2, "zr_next_cycle", 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0);
    step(2, "zr_after_cmt",  1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h0000, 1'b0);
    step(2, "zr_r1_normal",  1'b1, 3'd1, 16'hABCD, 3'd0, 3'd1, 16'h0000, 16'hABCD, 1'b0);
    step(2, "zr_r1_stage",   1'b0, 3'd0, 16'h0000, 3'd1, 3'd0, 16'hABCD, 16'h0000, 1'b0);

    // Six-register file: out-of-range writes/reads
    step(3, "n6_bad_write",   1'b1, 3'd7, 16'hAAAA, 3'd0, 3'd1, 16'h0000, 16'h0000, 1'b1);
    step(3, "n6_bad_read",    1'b0, 3'd0, 16'h0000, 3'd7, 3'd6, 16'h0000, 16'h0000, 1'b1);
    step(3, "n6_idle_badsel", 1'b0, 3'd7, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0);
    step(3, "n6_top_write",   1'b1, 3'd5, 16'h5555, 3'd5, 3'd5, 16'h5555, 16'h5555, 1'b0);
    step(3, "n6_top_stage",   1'b0, 3'd0, 16'h0000, 3'd4, 3'd5, 16'h0000, 16'h5555, 1'b0);
    step(3, "n6_top_array",   1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 16'h5555, 16'h0000, 1'b0);

    // Reset arrives while dut1 has a staged write pending
    step(1, "mid_write_r6", 1'b1, 3'd6, 16'h1111, 3'd6, 3'd5, 16'h1111, 16'h5678, 1'b0);
    step(1, "mid_staged",   1'b0, 3'd0, 16'h0000, 3'd6, 3'd5, 16'h1111, 16'h5678, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(0, "mid_in_reset", 1'b1, 3'd3, 16'h7777, 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b0);
    release_reset();
    step(1, "mid_stage_lost",  1'b0, 3'd0, 16'h0000, 3'd6, 3'd5, 16'h0000, 16'h0000, 1'b0);
    step(1, "mid_never_cmt",   1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 16'h0000, 16'h0000, 1'b0);
    step(0, "mid_ws0_cleared", 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b0);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_rf_bypass_pipe
`default_nettype wire
